// File: rtl/seg_counter.sv
// Segmented up/down counter with programmable modulus, parallel load and cascade enable.
// Segment carries come from registered per-segment flags, so no segment waits on a lower segment's adder.
module seg_counter #(
  parameter int              WIDTH   = 16,
  parameter int              SEG_W   = 4,
  parameter longint unsigned MODULUS = 64'd65536
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_up,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic [WIDTH-1:0] o_q,
  output logic             o_tc,
  output logic             o_wrap,
  output logic             o_ce_out
);

  localparam int               NSEG       = WIDTH / SEG_W;
  localparam logic [WIDTH-1:0] MAX_V      = WIDTH'(MODULUS - 64'd1);
  localparam logic             FULL_RANGE = (MODULUS == (64'd1 << WIDTH));

  logic [WIDTH-1:0] r_q;
  logic             r_wrap;
  logic             r_at_max;
  logic             r_at_zero;
  logic [NSEG-1:0]  r_seg_max;
  logic [NSEG-1:0]  r_seg_min;

  logic [NSEG:0]    w_carry;
  logic [WIDTH-1:0] w_cnt;
  logic [WIDTH-1:0] w_load_sat;
  logic             w_tc;
  logic             w_hit;
  logic [WIDTH-1:0] w_q_nxt;
  logic             w_wrap_nxt;
  logic [NSEG-1:0]  w_seg_max_nxt;
  logic [NSEG-1:0]  w_seg_min_nxt;

  // Carry into each segment: AND of the registered flags of every lower segment.
  always_comb begin
    w_carry    = '0;
    w_carry[0] = 1'b1;
    for (int s = 1; s <= NSEG; s++) begin
      w_carry[s] = w_carry[s-1] & (i_up ? r_seg_max[s-1] : r_seg_min[s-1]);
    end
  end

  // Per-segment step: each segment moves by one only when its carry-in is set.
  always_comb begin
    w_cnt = r_q;
    for (int s = 0; s < NSEG; s++) begin
      if (w_carry[s]) begin
        if (i_up) begin
          w_cnt[s*SEG_W +: SEG_W] = r_q[s*SEG_W +: SEG_W] + SEG_W'(1);
        end else begin
          w_cnt[s*SEG_W +: SEG_W] = r_q[s*SEG_W +: SEG_W] - SEG_W'(1);
        end
      end else begin
        w_cnt[s*SEG_W +: SEG_W] = r_q[s*SEG_W +: SEG_W];
      end
    end
  end

  // Terminal detection and the saturated load value.
  always_comb begin
    w_tc = i_up ? r_at_max : r_at_zero;
    if (FULL_RANGE) begin
      w_hit = w_carry[NSEG];
    end else begin
      w_hit = w_tc;
    end
    if (i_load_val > MAX_V) begin
      w_load_sat = MAX_V;
    end else begin
      w_load_sat = i_load_val;
    end
  end

  // Next-state selection with load > count > hold priority.
  always_comb begin
    w_q_nxt    = r_q;
    w_wrap_nxt = 1'b0;
    if (i_load) begin
      w_q_nxt    = w_load_sat;
      w_wrap_nxt = 1'b0;
    end else if (i_en) begin
      if (w_hit) begin
        w_q_nxt    = i_up ? {WIDTH{1'b0}} : MAX_V;
        w_wrap_nxt = 1'b1;
      end else begin
        w_q_nxt    = w_cnt;
        w_wrap_nxt = 1'b0;
      end
    end else begin
      w_q_nxt    = r_q;
      w_wrap_nxt = 1'b0;
    end
  end

  // Segment flags are derived from the next value so they stay coherent with q.
  always_comb begin
    w_seg_max_nxt = '0;
    w_seg_min_nxt = '0;
    for (int s = 0; s < NSEG; s++) begin
      w_seg_max_nxt[s] = &w_q_nxt[s*SEG_W +: SEG_W];
      w_seg_min_nxt[s] = ~|w_q_nxt[s*SEG_W +: SEG_W];
    end
  end

  // Count, wrap and flag registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_q       <= '0;
      r_wrap    <= 1'b0;
      r_at_max  <= 1'b0;
      r_at_zero <= 1'b1;
      r_seg_max <= '0;
      r_seg_min <= '1;
    end else begin
      r_q       <= w_q_nxt;
      r_wrap    <= w_wrap_nxt;
      r_at_max  <= (w_q_nxt == MAX_V);
      r_at_zero <= (w_q_nxt == {WIDTH{1'b0}});
      r_seg_max <= w_seg_max_nxt;
      r_seg_min <= w_seg_min_nxt;
    end
  end

  assign o_q      = r_q;
  assign o_wrap   = r_wrap;
  assign o_tc     = w_tc;
  assign o_ce_out = i_en & w_tc;

endmodule

// File: tb/tb_seg_counter.sv
// Scoreboard bench for seg_counter: MODULUS 65536, MODULUS 1000 and a 32-bit chain of two 16-bit instances.
module tb_seg_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        en_v [3];
  logic        up_v [3];
  logic        ld_v [3];
  logic [31:0] lv_v [3];

  logic [15:0] q0, q1, ql, qh;
  logic        tc0, wr0, ce0, tc1, wr1, ce1, tcl, wrl, cel, tch, wrh, ceh;

  seg_counter #(.WIDTH(16), .SEG_W(4), .MODULUS(64'd65536)) u_m64k (
    .i_clk(clk), .i_rst(rst), .i_en(en_v[0]), .i_up(up_v[0]), .i_load(ld_v[0]),
    .i_load_val(lv_v[0][15:0]), .o_q(q0), .o_tc(tc0), .o_wrap(wr0), .o_ce_out(ce0));

  seg_counter #(.WIDTH(16), .SEG_W(4), .MODULUS(64'd1000)) u_m1000 (
    .i_clk(clk), .i_rst(rst), .i_en(en_v[1]), .i_up(up_v[1]), .i_load(ld_v[1]),
    .i_load_val(lv_v[1][15:0]), .o_q(q1), .o_tc(tc1), .o_wrap(wr1), .o_ce_out(ce1));

  seg_counter #(.WIDTH(16), .SEG_W(4), .MODULUS(64'd65536)) u_lo (
    .i_clk(clk), .i_rst(rst), .i_en(en_v[2]), .i_up(up_v[2]), .i_load(ld_v[2]),
    .i_load_val(lv_v[2][15:0]), .o_q(ql), .o_tc(tcl), .o_wrap(wrl), .o_ce_out(cel));

  seg_counter #(.WIDTH(16), .SEG_W(4), .MODULUS(64'd65536)) u_hi (
    .i_clk(clk), .i_rst(rst), .i_en(cel), .i_up(up_v[2]), .i_load(ld_v[2]),
    .i_load_val(lv_v[2][31:16]), .o_q(qh), .o_tc(tch), .o_wrap(wrh), .o_ce_out(ceh));

  typedef struct {
    int          id;
    int          tag;
    logic [31:0] q;
    logic        tc;
    logic        wrap;
    logic        ce;
  } exp_t;

  exp_t            sb [$];
  longint unsigned mq [3];
  longint unsigned mod_v [3];
  int              total = 0;
  int              bad   = 0;
  int              cyc   = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", nm, cyc, act, exp_v);
    end
  endtask

  // Drive one edge of stimulus for counter id and push the expected post-edge state.
  task automatic drive(input int id, input logic en, input logic up, input logic ld, input logic [31:0] lv);
    exp_t            e;
    logic            w;
    longint unsigned lv64;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      en_v[i] = 1'b0;
      ld_v[i] = 1'b0;
    end
    en_v[id] = en;
    up_v[id] = up;
    ld_v[id] = ld;
    lv_v[id] = lv;
    lv64 = {32'h0, lv};
    w = 1'b0;
    if (ld) begin
      mq[id] = (lv64 < mod_v[id]) ? lv64 : mod_v[id] - 64'd1;
    end else if (en) begin
      if (up) begin
        if (mq[id] == mod_v[id] - 64'd1) begin mq[id] = 64'd0; w = 1'b1; end
        else mq[id] = mq[id] + 64'd1;
      end else begin
        if (mq[id] == 64'd0) begin mq[id] = mod_v[id] - 64'd1; w = 1'b1; end
        else mq[id] = mq[id] - 64'd1;
      end
    end
    e.id   = id;
    e.tag  = cyc + 1;
    e.q    = mq[id][31:0];
    e.wrap = w;
    e.tc   = up ? (mq[id] == mod_v[id] - 64'd1) : (mq[id] == 64'd0);
    e.ce   = en & e.tc;
    sb.push_back(e);
  endtask

  // Monitor: compare every due expectation shortly after the edge it belongs to.
  always @(posedge clk) begin
    exp_t        e;
    logic [31:0] aq;
    logic        atc, awr, ace;
    #1;
    while (sb.size() > 0 && sb[0].tag <= cyc) begin
      e = sb.pop_front();
      case (e.id)
        0:       begin aq = {16'h0, q0}; atc = tc0; awr = wr0; ace = ce0; end
        1:       begin aq = {16'h0, q1}; atc = tc1; awr = wr1; ace = ce1; end
        default: begin aq = {qh, ql};    atc = 1'b0; awr = wrh; ace = ceh; end
      endcase
      chk($sformatf("q[%0d]", e.id), aq, e.q);
      chk($sformatf("wrap[%0d]", e.id), {31'h0, awr}, {31'h0, e.wrap});
      chk($sformatf("ce_out[%0d]", e.id), {31'h0, ace}, {31'h0, e.ce});
      if (e.id != 2) chk($sformatf("tc[%0d]", e.id), {31'h0, atc}, {31'h0, e.tc});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    mod_v[0] = 64'd65536;
    mod_v[1] = 64'd1000;
    mod_v[2] = 64'h1_0000_0000;
    for (int i = 0; i < 3; i++) begin
      mq[i] = 64'd0; en_v[i] = 1'b0; up_v[i] = 1'b1; ld_v[i] = 1'b0; lv_v[i] = 32'h0;
    end
    up_v[1] = 1'b0;
    en_v[1] = 1'b1;
    rst = 1'b1;
    #12;
    chk("rst_q0", {16'h0, q0}, 32'h0);
    chk("rst_wrap0", {31'h0, wr0}, 32'h0);
    chk("rst_tc0_up", {31'h0, tc0}, 32'h0);
    chk("rst_ce0", {31'h0, ce0}, 32'h0);
    chk("rst_tc1_down", {31'h0, tc1}, 32'h1);
    chk("rst_ce1_down", {31'h0, ce1}, 32'h1);
    chk("rst_chain_q", {qh, ql}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    en_v[1] = 1'b0;

    // Full-range wrap window: FF00 -> FFFF (tc) -> 0000 (wrap) -> onward
    drive(0, 1'b0, 1'b1, 1'b1, 32'h0000_FF00);
    for (int k = 0; k < 300; k++) drive(0, 1'b1, 1'b1, 1'b0, 32'h0);

    // Cross-segment carry and borrow
    drive(0, 1'b0, 1'b1, 1'b1, 32'h0000_0FFF);
    drive(0, 1'b1, 1'b1, 1'b0, 32'h0);
    drive(0, 1'b1, 1'b0, 1'b0, 32'h0);
    drive(0, 1'b1, 1'b0, 1'b0, 32'h0);
    drive(0, 1'b0, 1'b0, 1'b1, 32'h0000_F000);
    drive(0, 1'b1, 1'b0, 1'b0, 32'h0);
    drive(0, 1'b1, 1'b1, 1'b0, 32'h0);

    // MODULUS 1000: up wrap, saturating load, down wrap, direction toggle
    drive(1, 1'b0, 1'b1, 1'b1, 32'd998);
    for (int k = 0; k < 3; k++) drive(1, 1'b1, 1'b1, 1'b0, 32'h0);
    drive(1, 1'b0, 1'b1, 1'b1, 32'd1200);
    drive(1, 1'b0, 1'b0, 1'b1, 32'd1);
    for (int k = 0; k < 3; k++) drive(1, 1'b1, 1'b0, 1'b0, 32'h0);
    drive(1, 1'b0, 1'b0, 1'b1, 32'd0);
    drive(1, 1'b0, 1'b1, 1'b0, 32'h0);
    drive(1, 1'b0, 1'b1, 1'b1, 32'd999);
    drive(1, 1'b1, 1'b1, 1'b1, 32'd5);
    for (int k = 0; k < 5; k++) drive(1, 1'b0, 1'b1, 1'b0, 32'h0);

    // Chained pair as one 32-bit counter
    drive(2, 1'b0, 1'b1, 1'b1, 32'h0000_FFF0);
    for (int k = 0; k < 40; k++) drive(2, 1'b1, 1'b1, 1'b0, 32'h0);
    drive(2, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8);
    for (int k = 0; k < 12; k++) drive(2, 1'b1, 1'b1, 1'b0, 32'h0);
    drive(2, 1'b0, 1'b0, 1'b1, 32'h0001_0003);
    for (int k = 0; k < 8; k++) drive(2, 1'b1, 1'b0, 1'b0, 32'h0);
    drive(2, 1'b0, 1'b0, 1'b1, 32'h0000_0002);
    for (int k = 0; k < 4; k++) drive(2, 1'b1, 1'b0, 1'b0, 32'h0);

    // Asynchronous reset mid-count at 0x1234
    drive(0, 1'b0, 1'b1, 1'b1, 32'h0000_1230);
    for (int k = 0; k < 4; k++) drive(0, 1'b1, 1'b1, 1'b0, 32'h0);
    @(posedge clk);
    #3;
    chk("pre_rst_q0", {16'h0, q0}, 32'h0000_1234);
    rst = 1'b1;
    en_v[0] = 1'b0;
    for (int i = 0; i < 3; i++) mq[i] = 64'd0;
    #1;
    chk("async_rst_q0", {16'h0, q0}, 32'h0);
    chk("async_rst_wrap0", {31'h0, wr0}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 1'b1, 1'b1, 1'b0, 32'h0);
    drive(0, 1'b1, 1'b1, 1'b0, 32'h0);

    repeat (3) @(posedge clk);
    #3;
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      total++;
      bad++;
      $display("FAIL unchecked id=%0d tag=%0d: got no check expected q=%0h", e.id, e.tag, e.q);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
